// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op-code constants and datapath width shared by the arbiter slice
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, cyclic search starting at ptr
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;

  // Two passes: indices ptr..NREQ-1 first, then wrap to 0..ptr-1.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = enable;
        gnt_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found   = 1'b1;
        gnt[i]  = enable;
        gnt_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU among NREQ requesters, registered result
// Optional illegal-op reporting on resp_err is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = 2,
  parameter int W    = ALU_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_srca,
  input  logic [NREQ*W-1:0] req_srcb,
  input  logic [NREQ*4-1:0] req_alucontrol,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_aluout,
  output logic              resp_zero,
  output logic              resp_err
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [W-1:0]   resp_aluout_q, resp_aluout_d;
  logic           resp_zero_q, resp_zero_d;

  logic            can_issue;
  logic            issue;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [W-1:0]    srca, srcb, diff, alu_res;
  logic [3:0]      op;
  logic            alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
  logic            op_bad;
  logic            resp_err_q, resp_err_d;
`endif

  assign can_issue = !resp_valid_q || resp_ready;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .enable  (can_issue),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign issue     = |gnt;

  // Operand select keys off the index, not the gated grant, so it never depends on backpressure.
  always_comb begin
    srca = '0;
    srcb = '0;
    op   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        srca = req_srca[i*W +: W];
        srcb = req_srcb[i*W +: W];
        op   = req_alucontrol[i*4 +: 4];
      end
    end
  end

  always_comb begin
    diff     = srca - srcb;
    alu_zero = (srca == srcb);
`ifdef ALU_ARB_OPCHECK_EN
    op_bad   = 1'b0;
`endif
    case (op)
      ALU_AND: alu_res = srca & srcb;
      ALU_OR:  alu_res = srca | srcb;
      ALU_ADD: alu_res = srca + srcb;
      ALU_SUB: alu_res = diff;
      ALU_SLT: alu_res = diff >> (W-1);
      default: begin
        alu_res = '0;
`ifdef ALU_ARB_OPCHECK_EN
        op_bad   = 1'b1;
        alu_zero = 1'b0;
`endif
      end
    endcase
  end

  always_comb begin
    ptr_d         = ptr_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_aluout_d = resp_aluout_q;
    resp_zero_d   = resp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
    resp_err_d    = resp_err_q;
`endif
    if (issue) begin
      resp_valid_d  = 1'b1;
      resp_id_d     = gnt_idx;
      resp_aluout_d = alu_res;
      resp_zero_d   = alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
      resp_err_d    = op_bad;
`endif
      ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_aluout_q <= '0;
      resp_zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      resp_err_q    <= 1'b0;
`endif
    end else begin
      ptr_q         <= ptr_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_aluout_q <= resp_aluout_d;
      resp_zero_q   <= resp_zero_d;
`ifdef ALU_ARB_OPCHECK_EN
      resp_err_q    <= resp_err_d;
`endif
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_aluout = resp_aluout_q;
  assign resp_zero   = resp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign resp_err    = resp_err_q;
`else
  assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter (NREQ=3, W=32)
module tb_alu_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 2;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_srca;
  logic [NREQ*W-1:0] req_srcb;
  logic [NREQ*4-1:0] req_alucontrol;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_aluout;
  logic              resp_zero;
  logic              resp_err;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_srca       (req_srca),
    .req_srcb       (req_srcb),
    .req_alucontrol (req_alucontrol),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_aluout    (resp_aluout),
    .resp_zero      (resp_zero),
    .resp_err       (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] out;
    logic        zero;
    logic        err;
  } res_t;

  res_t sb[$];
  res_t last_exp;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input int id, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [31:0] d;
    d      = a - b;
    r.id   = id[1:0];
    r.zero = (a == b);
    r.err  = 1'b0;
    case (op)
      4'b0000: r.out = a & b;
      4'b0001: r.out = a | b;
      4'b0010: r.out = a + b;
      4'b0110: r.out = d;
      4'b0111: r.out = {31'd0, d[31]};
      default: begin
        r.out = 32'd0;
`ifdef ALU_ARB_OPCHECK_EN
        r.zero = 1'b0;
        r.err  = 1'b1;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_srca[i*W +: W]       = a;
    req_srcb[i*W +: W]       = b;
    req_alucontrol[i*4 +: 4] = op;
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic cycle(input logic [2:0] exp_rdy, input bit chk_rdy);
    logic [2:0] hs;
    res_t e;
    #1;
    if (chk_rdy) chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    hs = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++)
      if (hs[i] && !reset)
        sb.push_back(model(i, req_alucontrol[i*4 +: 4], req_srca[i*W +: W], req_srcb[i*W +: W]));
    @(posedge clk);
    #1;
    if (reset) begin
      sb.delete();
      last_exp = '0;
    end else if (hs != 3'b000) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        last_exp = e;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_aluout", resp_aluout, e.out);
        chk("resp_zero", 32'(resp_zero), 32'(e.zero));
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
    @(negedge clk);
  endtask

  task automatic hold_check();
    chk("hold_valid", 32'(resp_valid), 32'd1);
    chk("hold_id", 32'(resp_id), 32'(last_exp.id));
    chk("hold_aluout", resp_aluout, last_exp.out);
    chk("hold_zero", 32'(resp_zero), 32'(last_exp.zero));
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_aluout"}, resp_aluout, 32'd0);
    chk({tag, "_zero"}, 32'(resp_zero), 32'd0);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = '0;
    req_srca       = '0;
    req_srcb       = '0;
    req_alucontrol = '0;
    resp_ready     = 1'b0;
    last_exp       = '0;
    repeat (2) @(negedge clk);
    zero_check("reset");
    reset = 1'b0;

    // Round-robin with all requesters valid and a free consumer
    set_req(0, 32'd10, 32'd5, 4'b0010);
    set_req(1, 32'd10, 32'd3, 4'b0110);
    set_req(2, 32'h0000_00F0, 32'h0000_000F, 4'b0001);
    req_valid  = 3'b111;
    resp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle(3'b001, 1'b1);
      cycle(3'b010, 1'b1);
      cycle(3'b100, 1'b1);
    end

    req_valid = 3'b000;
    cycle(3'b000, 1'b1);
    chk("idle_valid", 32'(resp_valid), 32'd0);

    set_req(0, 32'd3, 32'd1, 4'b0010);
    req_valid = 3'b001;
    cycle(3'b001, 1'b1);
    chk("add_lit", resp_aluout, 32'd4);

    set_req(0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000);
    cycle(3'b001, 1'b1);
    chk("and_lit", resp_aluout, 32'h0F00_0F00);

    req_valid = 3'b010;
    set_req(1, 32'd4, 32'hFFFF_FFFE, 4'b0110);
    cycle(3'b010, 1'b1);
    chk("sub_lit", resp_aluout, 32'd6);
    set_req(1, 32'd7, 32'd7, 4'b0110);
    cycle(3'b010, 1'b1);
    chk("sub_zero_lit", 32'(resp_zero), 32'd1);
    set_req(1, 32'd1, 32'd2, 4'b0111);
    cycle(3'b010, 1'b1);
    chk("slt12_lit", resp_aluout, 32'd1);
    set_req(1, 32'd2, 32'd1, 4'b0111);
    cycle(3'b010, 1'b1);
    chk("slt21_lit", resp_aluout, 32'd0);

    // Backpressure: result held, no grants until the consumer frees the register
    resp_ready = 1'b0;
    set_req(2, 32'hFFFF_FFFF, 32'd2, 4'b0010);
    req_valid = 3'b100;
    repeat (3) begin
      cycle(3'b000, 1'b1);
      hold_check();
    end
    resp_ready = 1'b1;
    cycle(3'b100, 1'b1);
    chk("bp_issue_lit", resp_aluout, 32'd1);

    // Reset while a result is valid and requests are pending
    req_valid = 3'b111;
    set_req(0, 32'd1, 32'd1, 4'b0010);
    reset = 1'b1;
    cycle(3'b000, 1'b0);
    zero_check("midreset");
    reset = 1'b0;
    cycle(3'b001, 1'b1);

    // Unsupported op code with equal operands
    req_valid = 3'b010;
    set_req(1, 32'd5, 32'd5, 4'b1111);
    cycle(3'b010, 1'b1);
    chk("illegal_out", resp_aluout, 32'd0);
`ifdef ALU_ARB_OPCHECK_EN
    chk("illegal_zero", 32'(resp_zero), 32'd0);
    chk("illegal_err", 32'(resp_err), 32'd1);
`else
    chk("illegal_zero", 32'(resp_zero), 32'd1);
    chk("illegal_err", 32'(resp_err), 32'd0);
`endif

    req_valid = 3'b000;
    cycle(3'b000, 1'b1);
    chk("drain_valid", 32'(resp_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU datapath among NREQ independent requesters, such as the main pipeline, the branch/address unit and a debug port. Uses round-robin arbitration with a per-requester valid/ready handshake. Each cycle at most one operation is issued to the ALU. The result, the zero flag and the requester id are captured in a one-entry output register with valid/ready backpressure.

Parameters:
NREQ, 3, number of requesters (2..8)
IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ
W, 32, operand/result width (fixed by the ALU; the parameter exists for checks only)

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester accept (combinational)
req_srca  in  NREQ*W  packed operand A; requester i at [i*W +: W]
req_srcb  in  NREQ*W  packed operand B
req_alucontrol  in  NREQ*4  packed ALU op codes
resp_valid  out  1  result register holds a valid result
resp_ready  in  1  consumer accepts the result
resp_id  out  IDW  index of the requester that issued the result
resp_aluout  out  W  registered ALU result
resp_zero  out  1  registered zero flag (srca == srcb)
resp_err  out  1  illegal-op flag (see Optional Feature)

Behaviour:
- Reset values: resp_valid=0, resp_id=0, resp_aluout=0, resp_zero=0, resp_err=0. The round-robin pointer is set so requester 0 has top priority. Reset overrides everything, including a pending result or handshake in the same cycle; pending results are discarded.
- Supported ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT. SLT is defined as (srca-srcb)>>31, an unsigned shift of the difference.
  - All arithmetic is modulo 2**W; there are no overflow flags.
- Other codes produce resp_aluout=0. The block must never hold a stale value.
- can_issue = !resp_valid | resp_ready. The output register therefore sustains one operation per cycle under continuous consumption.
- Grant: the first requester i with req_valid[i]=1, searched cyclically starting at ptr. The grant is computed combinationally.
  - req_ready[i] = can_issue & grant[i]. At most one bit of req_ready is high.
  - req_ready never depends on req_srca, req_srcb or req_alucontrol.
- Issue: on a cycle where req_valid[i] & req_ready[i], the next clock edge:
  - loads resp_aluout, resp_zero and resp_id=i;
  - sets resp_valid=1;
  - sets ptr=(i+1) mod NREQ.
- Latency is exactly 1 cycle from handshake to resp_valid.
- Pointer wrap: when i = NREQ-1, ptr becomes 0.
- Idle: no valid request and can_issue. If resp_ready, resp_valid is cleared to 0. ptr is unchanged.
- Backpressure: while resp_valid & !resp_ready, all req_ready=0 and the response outputs are held stable. ptr is unchanged.
- Simultaneous consume and issue: the register is overwritten with the new result and resp_valid stays 1, with no bubble.
- Fairness: any requester holding req_valid is served within NREQ issue slots.
- Requesters must hold their operands and req_valid stable until accepted. Dropping req_valid before acceptance is legal; the request is simply not issued.

Optional Feature:
Macro ALU_ARB_OPCHECK_EN.
- Defined: an unsupported alucontrol code is still accepted and consumes its slot. The result register gets resp_aluout=0, resp_zero=0 and resp_err=1.
- Not defined: resp_err is tied to 0. An unsupported code returns aluout=0, and resp_zero keeps the normal (srca==srcb) value.

Decomposition:
- Package alu_pkg: op-code constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111; ALU_W=32.
- One natural sub-module, rr_arbiter (NREQ): inputs req, ptr and enable; outputs a one-hot grant and a binary grant index.
- The operand mux and op evaluation stay in alu_arbiter. The existing combinational ALU is not reused, because it retains its output on unlisted codes.

Test Plan:
- Single ADD: req0 sends 3+1 with op 0010 and resp_ready=1 → req_ready[0]=1 that cycle; next cycle resp_valid=1, resp_aluout=4, resp_id=0, resp_zero=0.
- Round-robin: all three requesters continuously valid, resp_ready=1 → grants 0,1,2,0,1,2 on consecutive cycles with no bubble.
- SUB/zero/SLT:
  - req1 SUB 4-(-2) → 6, zero=0.
  - req1 SUB 7-7 → 0, zero=1.
  - SLT 1,2 → 1.
  - SLT 2,1 → 0.
- Backpressure: hold resp_ready=0 for 3 cycles with req2 valid → req_ready=0 and the response stays stable. When resp_ready rises, req2 is issued in that same cycle and resp_valid never drops.
- Reset mid-stream: assert reset while resp_valid=1 and requests are pending → next cycle all outputs are 0. The first grant after reset goes to req0.
- Illegal op 1111 with A=B=5:
  - with ALU_ARB_OPCHECK_EN: resp_aluout=0, resp_zero=0, resp_err=1;
  - without it: resp_aluout=0, resp_zero=1, resp_err=0.
